// File: rtl/l_preamble_pkg.sv
// Shared constants and state encoding for the legacy 802.11a/g preamble sequencer.
package l_preamble_pkg;

  localparam int N_STF   = 160;
  localparam int LTF_SYM = 64;
  localparam int N_TOTAL = 320;
  localparam int IQ_W    = 16;
  localparam int IDX_W   = $clog2(N_TOTAL + 1);

  typedef enum logic [2:0] {
    IDLE,
    STF,
    LTF_GI,
    LTF1,
    LTF2,
    DRAIN
  } state_t;

endpackage

// File: rtl/l_preamble_iq_half_avg.sv
// Per-component (a+b)>>>1 on packed I/Q words; halve mode zeroes b so the same
// 17-bit sum path yields a>>>1.
module iq_half_avg
  import l_preamble_pkg::*;
(
  input  logic [2*IQ_W-1:0] a,
  input  logic [2*IQ_W-1:0] b,
  input  logic              halve,
  output logic [2*IQ_W-1:0] y
);

  logic [2*IQ_W-1:0] b_eff;
  logic [IQ_W:0]     sum_i;
  logic [IQ_W:0]     sum_q;

  always_comb begin
    b_eff = halve ? '0 : b;
    sum_i = {a[2*IQ_W-1], a[2*IQ_W-1:IQ_W]} + {b_eff[2*IQ_W-1], b_eff[2*IQ_W-1:IQ_W]};
    sum_q = {a[IQ_W-1], a[IQ_W-1:0]} + {b_eff[IQ_W-1], b_eff[IQ_W-1:0]};
    // dropping the sum's lsb is the arithmetic shift; sign lives in bit IQ_W
    y = {IQ_W'(sum_i >> 1), IQ_W'(sum_q >> 1)};
  end

endmodule

// File: rtl/l_preamble_seq.sv
// Legacy preamble sequencer: walks the L-STF / L-LTF ROMs and streams 320
// windowed samples on a valid/ready interface.
//
// state  | meaning
// IDLE   | waiting for start, outputs quiet
// STF    | loading STF periods (idx 0..159)
// LTF_GI | loading LTF double guard (idx 160..191)
// LTF1   | loading first LTF symbol (idx 192..255)
// LTF2   | loading second LTF symbol (idx 256..319)
// DRAIN  | holding sample 319 until accepted
module l_preamble_seq
  import l_preamble_pkg::*;
#(
  parameter int STF_REPS   = N_STF / 16,
  parameter int LTF_GI_LEN = 32,
  parameter int WINDOW_EN  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic [3:0]        stf_addr,
  input  logic [2*IQ_W-1:0] stf_data,
  output logic [5:0]        ltf_addr,
  input  logic [2*IQ_W-1:0] ltf_data,
  output logic [2*IQ_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy,
  output logic              done
);

  localparam int STF_END  = STF_REPS * 16;
  localparam int GI_END   = STF_END + LTF_GI_LEN;
  localparam int LTF1_END = GI_END + LTF_SYM;
  localparam int LAST_IDX = LTF1_END + LTF_SYM - 1;

  state_t            state, state_nx;
  logic [IDX_W-1:0]  idx;
  logic              ld;
  logic              hs;
  logic              win_halve;
  logic              win_avg;
  logic [2*IQ_W-1:0] win_word;
  logic [2*IQ_W-1:0] sample;

  assign hs   = m_valid && m_ready;
  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ld       = 1'b0;
    stf_addr = '0;
    ltf_addr = '0;
    case (state)
      IDLE: begin
        if (start) state_nx = STF;
      end
      STF: begin
        ld       = !m_valid || m_ready;
        stf_addr = idx[3:0];
        if (ld && idx == IDX_W'(STF_END - 1)) state_nx = LTF_GI;
      end
      LTF_GI: begin
        // stf_addr stays 0 here, which supplies STF word 0 for the boundary average
        ld       = !m_valid || m_ready;
        ltf_addr = 6'(idx - IDX_W'(STF_END) + IDX_W'(LTF_SYM - LTF_GI_LEN));
        if (ld && idx == IDX_W'(GI_END - 1)) state_nx = LTF1;
      end
      LTF1: begin
        ld       = !m_valid || m_ready;
        ltf_addr = 6'(idx - IDX_W'(GI_END));
        if (ld && idx == IDX_W'(LTF1_END - 1)) state_nx = LTF2;
      end
      LTF2: begin
        ld       = !m_valid || m_ready;
        ltf_addr = 6'(idx - IDX_W'(GI_END));
        if (ld && idx == IDX_W'(LAST_IDX)) state_nx = DRAIN;
      end
      DRAIN: begin
        if (hs) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (abort) state_nx = IDLE;
  end

  assign win_halve = (WINDOW_EN != 0) && (state == STF) && (idx == '0);
  assign win_avg   = (WINDOW_EN != 0) && (state == LTF_GI) && (idx == IDX_W'(STF_END));

  iq_half_avg u_win (
    .a     (stf_data),
    .b     (ltf_data),
    .halve (win_halve),
    .y     (win_word)
  );

  always_comb begin
    sample = (state == STF) ? stf_data : ltf_data;
    if (win_halve || win_avg) sample = win_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= '0;
      m_data  <= '0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= (state == DRAIN) && hs && !abort;
      if (abort) begin
        idx     <= '0;
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end else if (ld) begin
        m_data  <= sample;
        m_valid <= 1'b1;
        m_last  <= (idx == IDX_W'(LAST_IDX));
        idx     <= idx + 1'b1;
      end else begin
        if (hs) begin
          m_valid <= 1'b0;
          m_last  <= 1'b0;
        end
        if (state == IDLE) idx <= '0;
      end
    end
  end

endmodule

// File: tb/tb_l_preamble_seq.sv
// Scoreboard bench for l_preamble_seq: expected samples are queued at start and
// matched against each output handshake.
module tb_l_preamble_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [3:0]  stf_addr;
  logic [31:0] stf_data;
  logic [5:0]  ltf_addr;
  logic [31:0] ltf_data;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic        busy;
  logic        done;

  logic [31:0] stf_rom [16];
  logic [31:0] ltf_rom [64];

  int          n_cmp  = 0;
  int          n_mis  = 0;
  int          hs_cnt = 0;
  logic [32:0] sb [$];
  logic        prev_stall = 1'b0;
  logic [32:0] prev_out;
  logic [32:0] mon_exp;

  assign stf_data = stf_rom[stf_addr];
  assign ltf_data = ltf_rom[ltf_addr];

  always #5 clk = ~clk;

  l_preamble_seq dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .stf_addr (stf_addr),
    .stf_data (stf_data),
    .ltf_addr (ltf_addr),
    .ltf_data (ltf_data),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_last   (m_last),
    .busy     (busy),
    .done     (done)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] half16(input logic [15:0] a);
    int s;
    s = $signed(a);
    return 16'(s >>> 1);
  endfunction

  function automatic logic [15:0] avg16(input logic [15:0] a, input logic [15:0] b);
    int s;
    s = int'($signed(a)) + int'($signed(b));
    return 16'(s >>> 1);
  endfunction

  function automatic logic [31:0] exp_sample(input int i);
    logic [31:0] w;
    if (i == 0)
      w = {half16(stf_rom[0][31:16]), half16(stf_rom[0][15:0])};
    else if (i < 160)
      w = stf_rom[i % 16];
    else if (i == 160)
      w = {avg16(stf_rom[0][31:16], ltf_rom[32][31:16]),
           avg16(stf_rom[0][15:0], ltf_rom[32][15:0])};
    else if (i < 192)
      w = ltf_rom[i - 128];
    else
      w = ltf_rom[(i - 192) % 64];
    return w;
  endfunction

  task automatic push_run();
    for (int i = 0; i < 320; i++) sb.push_back({i == 319, exp_sample(i)});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag, input bit rnd);
    bit got = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (rnd) m_ready = 1'($urandom_range(0, 1));
      tick();
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    m_ready = 1'b1;
    chk({tag, "_done"}, got, 1'b1);
    chk({tag, "_hs"}, hs_cnt, 320);
    chk({tag, "_sb_left"}, sb.size(), 0);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  always @(negedge clk) begin
    if (prev_stall && m_valid) chk("stall_hold", {m_last, m_data}, prev_out);
    if (m_valid && m_ready) begin
      hs_cnt++;
      if (sb.size() == 0) chk("sb_extra", m_valid, 1'b0);
      else begin
        mon_exp = sb.pop_front();
        chk("sample", {m_last, m_data}, mon_exp);
      end
    end
    prev_stall = m_valid && !m_ready;
    prev_out   = {m_last, m_data};
  end

  initial begin
    for (int i = 0; i < 16; i++) stf_rom[i] = {16'(i * 911 + 3), 16'((i * 409) ^ 32'h5a5a)};
    for (int i = 0; i < 64; i++) ltf_rom[i] = {16'(i * 1237 + 5), 16'((i * 77) ^ 32'ha00f)};
    stf_rom[0]  = 32'h02f2_02f2;
    stf_rom[1]  = 32'hfd0e_02f2;
    ltf_rom[32] = 32'hfd0e_0100;

    rst = 1'b1; start = 1'b0; abort = 1'b0; m_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_valid", m_valid, 1'b0);
    chk("rst_last", m_last, 1'b0);
    chk("rst_data", m_data, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_stf_addr", stf_addr, 4'h0);
    chk("rst_ltf_addr", ltf_addr, 6'h0);

    // full run, m_ready held high, cycle-exact
    hs_cnt = 0;
    start = 1'b1; push_run(); tick(); start = 1'b0;
    chk("r1_busy_on", busy, 1'b1);
    chk("r1_valid_early", m_valid, 1'b0);
    tick();
    chk("r1_s0", m_data, 32'h0179_0179);
    chk("r1_s0_valid", m_valid, 1'b1);
    tick();
    chk("r1_s1", m_data, 32'hfd0e_02f2);
    repeat (15) tick();
    chk("r1_s16", m_data, 32'h02f2_02f2);
    repeat (144) tick();
    chk("r1_s160", m_data, 32'h0000_01f9);
    repeat (159) tick();
    chk("r1_last", m_last, 1'b1);
    chk("r1_last_valid", m_valid, 1'b1);
    tick();
    chk("r1_done", done, 1'b1);
    chk("r1_busy_off", busy, 1'b0);
    chk("r1_valid_off", m_valid, 1'b0);
    chk("r1_hs", hs_cnt, 320);
    chk("r1_sb_left", sb.size(), 0);

    // restart in the done cycle, random backpressure
    hs_cnt = 0;
    start = 1'b1; push_run(); tick(); start = 1'b0;
    chk("r2_done_pulse", done, 1'b0);
    chk("r2_busy_on", busy, 1'b1);
    wait_done("r2", 1'b1);

    // start while busy ignored, abort in LTF1
    hs_cnt = 0;
    start = 1'b1; push_run(); tick(); start = 1'b0;
    repeat (50) tick();
    start = 1'b1; tick(); start = 1'b0;
    repeat (149) tick();
    abort = 1'b1; tick(); abort = 1'b0;
    chk("ab_valid", m_valid, 1'b0);
    chk("ab_busy", busy, 1'b0);
    chk("ab_last", m_last, 1'b0);
    chk("ab_done", done, 1'b0);
    chk("ab_hs", hs_cnt, 200);
    tick();
    chk("ab_done_late", done, 1'b0);
    sb.delete();
    hs_cnt = 0;
    start = 1'b1; push_run(); tick(); start = 1'b0;
    tick();
    chk("ab_restart_s0", m_data, 32'h0179_0179);
    wait_done("ab_restart", 1'b0);

    // same-cycle start and abort from IDLE
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    chk("sa_busy", busy, 1'b0);
    tick();
    chk("sa_valid", m_valid, 1'b0);
    chk("sa_busy2", busy, 1'b0);

    // negative component halving
    stf_rom[0] = 32'hfd0e_fd0e;
    hs_cnt = 0;
    start = 1'b1; push_run(); tick(); start = 1'b0;
    tick();
    chk("neg_half", m_data, 32'hfe87_fe87);
    wait_done("neg", 1'b0);

    // reset mid-run
    start = 1'b1; push_run(); tick(); start = 1'b0;
    repeat (20) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    sb.delete();
    chk("mr_data", m_data, 32'h0);
    chk("mr_valid", m_valid, 1'b0);
    chk("mr_busy", busy, 1'b0);
    tick();
    chk("mr_done", done, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
